// File: rtl/movavg_rr_scheduler_pkg.sv
// movavg_rr_scheduler_types: shared types and default sizes for the moving-average scheduler
// Contents: default parameter values, sample/sum/channel/pointer types, FSM state enum.
package movavg_rr_scheduler_types;
  localparam int DEF_NCH = 4;
  localparam int DEF_DW = 8;
  localparam int DEF_WIN_LOG2 = 2;
  localparam int DEF_CW = $clog2(DEF_NCH);
  typedef logic signed [DEF_DW-1:0] sample_t;
  typedef logic signed [DEF_DW+DEF_WIN_LOG2-1:0] sum_t;
  typedef logic [DEF_CW-1:0] chan_t;
  typedef logic [DEF_WIN_LOG2-1:0] ptr_t;
  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_e;
endpackage

// File: rtl/movavg_rr_arbiter.sv
// movavg_rr_arbiter: combinational round-robin arbiter
// Ports:
//   req [NCH]  request bits
//   ptr [CW]   highest-priority channel
//   gnt [NCH]  one-hot grant (zero when no request)
//   idx [CW]   granted channel index
//   any        at least one request present
module movavg_rr_arbiter #(
  parameter int NCH = 4,
  localparam int CW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [CW-1:0]  idx,
  output logic           any
);
  int best, d;
  // Pick the requester with the smallest wrapped distance from ptr.
  always_comb begin
    best = NCH;
    d = 0;
    idx = '0;
    any = |req;
    for (int c = 0; c < NCH; c++) begin
      d = (c - int'(ptr) + NCH) % NCH;
      if (req[c] && d < best) begin
        best = d;
        idx = CW'(c);
      end
    end
    gnt = any ? (NCH'(1) << idx) : '0;
  end
endmodule

// File: rtl/movavg_rr_scheduler.sv
// movavg_rr_scheduler: round-robin shared moving-average engine over NCH sample channels
// Ports:
//   system1000       clock
//   system1000_rstn  asynchronous reset, active low
//   clear            synchronous clear of all histories, sums, pointers and in-flight work
//   req_valid/req_ready/req_data  per-channel sample handshake (channel i at [i*DW +: DW])
//   out_valid/out_ready/out_data/out_chan  averaged result with its channel index
// Build option: MOVAVG_RR_SCHEDULER_ROUND_EN selects round-half-up instead of floor.
module movavg_rr_scheduler
  import movavg_rr_scheduler_types::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int DW = DEF_DW,
  parameter int WIN_LOG2 = DEF_WIN_LOG2,
  localparam int CW = $clog2(NCH),
  localparam int SW = DW + WIN_LOG2,
  localparam int WIN = 2 ** WIN_LOG2
) (
  input  logic                 system1000,
  input  logic                 system1000_rstn,
  input  logic                 clear,
  input  logic [NCH-1:0]       req_valid,
  input  logic [NCH*DW-1:0]    req_data,
  output logic [NCH-1:0]       req_ready,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_data,
  output logic [CW-1:0]        out_chan,
  input  logic                 out_ready
);
  state_e state, state_n;
  logic [NCH-1:0] gnt;
  logic [CW-1:0] idx, g_q, rr;
  logic any, accept;
  logic signed [DW-1:0] smp, sel, oldest, avg;
  logic signed [SW-1:0] new_sum;
  logic signed [DW-1:0] hist [NCH][WIN];
  logic signed [SW-1:0] sum [NCH];
  logic [WIN_LOG2-1:0] wp [NCH];
`ifdef MOVAVG_RR_SCHEDULER_ROUND_EN
  localparam logic signed [SW-1:0] HALF = SW'(2 ** (WIN_LOG2 - 1));
`endif

  movavg_rr_arbiter #(.NCH(NCH)) u_arb (
    .req(req_valid),
    .ptr(rr),
    .gnt(gnt),
    .idx(idx),
    .any(any)
  );

  always_ff @(posedge system1000 or negedge system1000_rstn)
    if (!system1000_rstn) state <= IDLE;
    else state <= state_n;

  // clear overrides any accept in the same cycle
  always_comb begin
    accept = state == IDLE && any && !clear;
    req_ready = accept ? gnt : '0;
    out_valid = state == HOLD;
    state_n = clear ? IDLE :
              state == IDLE ? (any ? CALC : IDLE) :
              state == CALC ? HOLD :
              out_ready ? IDLE : HOLD;
  end

  always_comb begin
    sel = '0;
    for (int c = 0; c < NCH; c++)
      if (idx == CW'(c)) sel = req_data[c*DW +: DW];
    oldest = hist[g_q][wp[g_q]];
    new_sum = sum[g_q] - SW'(oldest) + SW'(smp);
`ifdef MOVAVG_RR_SCHEDULER_ROUND_EN
    avg = DW'((new_sum + HALF) >>> WIN_LOG2);
`else
    avg = DW'(new_sum >>> WIN_LOG2);
`endif
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      g_q <= '0;
      rr <= '0;
      smp <= '0;
      out_data <= '0;
      out_chan <= '0;
      for (int c = 0; c < NCH; c++) begin
        sum[c] <= '0;
        wp[c] <= '0;
        for (int w = 0; w < WIN; w++) hist[c][w] <= '0;
      end
    end else if (clear) begin
      rr <= '0;
      for (int c = 0; c < NCH; c++) begin
        sum[c] <= '0;
        wp[c] <= '0;
        for (int w = 0; w < WIN; w++) hist[c][w] <= '0;
      end
    end else begin
      if (accept) begin
        g_q <= idx;
        smp <= sel;
        rr <= (idx == CW'(NCH - 1)) ? '0 : idx + 1'b1;
      end
      if (state == CALC) begin
        sum[g_q] <= new_sum;
        hist[g_q][wp[g_q]] <= smp;
        wp[g_q] <= wp[g_q] + 1'b1;
        out_data <= avg;
        out_chan <= g_q;
      end
    end
  end
endmodule

// File: tb/tb_movavg_rr_scheduler.sv
// tb_movavg_rr_scheduler: scoreboard bench for movavg_rr_scheduler (NCH=4, DW=8, WIN=4)
module tb_movavg_rr_scheduler;
  logic clk, rst_n, clear, out_ready, out_valid;
  logic [3:0] req_valid, req_ready;
  logic [31:0] req_data;
  logic signed [7:0] out_data;
  logic [1:0] out_chan;

  typedef struct {int ch; int data; int cyc;} exp_t;
  exp_t sb[$];
  int src_q[4][$];
  int hm[4][4];
  int wm[4];
  int acc_log[$], acc_cyc[$], out_log[$];
  int errors = 0, checks = 0, cyc = 0;
  bit ov_prev = 0;

  movavg_rr_scheduler dut (
    .system1000(clk),
    .system1000_rstn(rst_n),
    .clear(clear),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_chan(out_chan),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int avg4(input int s);
    int t;
    t = s;
`ifdef MOVAVG_RR_SCHEDULER_ROUND_EN
    t = t + 2;
`endif
    return (t - (((t % 4) + 4) % 4)) / 4;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      wm[c] = 0;
      for (int w = 0; w < 4; w++) hm[c][w] = 0;
    end
    sb.delete();
  endtask

  task automatic drive();
    for (int c = 0; c < 4; c++) begin
      req_valid[c] = src_q[c].size() > 0;
      req_data[c*8 +: 8] = req_valid[c] ? 8'(src_q[c][0]) : 8'h0;
    end
  endtask

  task automatic push(input int c, input int v);
    src_q[c].push_back(v);
    drive();
  endtask

  task automatic model_accept(input int c);
    exp_t e;
    int s;
    hm[c][wm[c]] = src_q[c][0];
    wm[c] = (wm[c] + 1) % 4;
    s = 0;
    for (int w = 0; w < 4; w++) s += hm[c][w];
    e.ch = c;
    e.data = avg4(s);
    e.cyc = cyc;
    sb.push_back(e);
    acc_log.push_back(c);
    acc_cyc.push_back(cyc);
  endtask

  // One clock: observe at negedge, then update sources just after posedge.
  task automatic tick();
    logic [3:0] acc;
    exp_t e;
    @(negedge clk);
    cyc++;
    acc = req_ready & req_valid;
    if (rst_n) chk("ready_onehot", 32'($onehot0(req_ready)), 1);
    if (clear) model_reset();
    else if (rst_n) begin
      for (int c = 0; c < 4; c++) if (acc[c]) model_accept(c);
      if (out_valid && !ov_prev) begin
        if (sb.size() == 0) chk("latency_no_pending", 1, 0);
        else chk("latency", cyc - sb[0].cyc, 2);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("spurious_output", 1, 0);
        else begin
          e = sb.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_chan", {30'b0, out_chan}, e.ch);
          out_log.push_back(int'(out_data));
        end
      end
    end
    ov_prev = out_valid;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) if (acc[c] && !clear) void'(src_q[c].pop_front());
    drive();
  endtask

  function automatic bit busy();
    bit b;
    b = out_valid || sb.size() > 0;
    for (int c = 0; c < 4; c++) if (src_q[c].size() > 0) b = 1;
    return b;
  endfunction

  task automatic drain(input int max);
    for (int i = 0; i < max && busy(); i++) tick();
    chk("drain_timeout", 32'(busy()), 0);
  endtask

  task automatic wait_valid(input int max);
    for (int i = 0; i < max && !out_valid; i++) tick();
    chk("wait_valid_timeout", 32'(out_valid), 1);
  endtask

  task automatic do_reset();
    rst_n = 0;
    for (int c = 0; c < 4; c++) src_q[c].delete();
    drive();
    model_reset();
    tick();
    tick();
    rst_n = 1;
    ov_prev = 0;
  endtask

  task automatic pulse_clear();
    clear = 1;
    tick();
    clear = 0;
  endtask

  task automatic clear_logs();
    acc_log.delete();
    acc_cyc.delete();
    out_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int exp2[5] = '{2, 4, 6, 8, 6};
    clk = 0;
    clear = 0;
    out_ready = 1;
    req_valid = '0;
    req_data = '0;
    rst_n = 1;
    #1;
    do_reset();
    // reset state held with no requests
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_req_ready", {28'b0, req_ready}, 0);
      chk("idle_out_valid", 32'(out_valid), 0);
      chk("idle_out_data", out_data, 0);
      chk("idle_out_chan", {30'b0, out_chan}, 0);
    end
    // ch0 fills its window: partial sums then a full window
    clear_logs();
    push(0, 8); push(0, 8); push(0, 8); push(0, 8); push(0, 0);
    drain(60);
    chk("t2_count", out_log.size(), 5);
    for (int i = 0; i < 5 && i < out_log.size(); i++) chk("t2_value", out_log[i], exp2[i]);
    // simultaneous ch0/ch1 after reset
    do_reset();
    clear_logs();
    push(0, 100);
    push(1, -6);
    drain(40);
    push(0, 100);
    drain(40);
    chk("t3_count", out_log.size(), 3);
    if (out_log.size() == 3) begin
      chk("t3_grant0", acc_log[0], 0);
      chk("t3_grant1", acc_log[1], 1);
      chk("t3_ch0", out_log[0], 25);
`ifdef MOVAVG_RR_SCHEDULER_ROUND_EN
      chk("t3_ch1", out_log[1], -1);
`else
      chk("t3_ch1", out_log[1], -2);
`endif
      chk("t3_ch0_again", out_log[2], 50);
    end
    // all channels continuously requesting
    pulse_clear();
    clear_logs();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 4; c++) push(c, int'($urandom_range(0, 255)) - 128);
    drain(100);
    chk("t4_accepts", acc_log.size(), 8);
    if (acc_log.size() >= 6) begin
      for (int i = 0; i < 6; i++) chk("t4_order", acc_log[i], i % 4);
      for (int i = 1; i < 6; i++) chk("t4_spacing", acc_cyc[i] - acc_cyc[i-1], 3);
    end
    // backpressure in HOLD
    out_ready = 0;
    push(3, 20);
    push(0, 12);
    wait_valid(20);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_valid", 32'(out_valid), 1);
      if (sb.size() > 0) begin
        chk("t5_hold_data", out_data, sb[0].data);
        chk("t5_hold_chan", {30'b0, out_chan}, sb[0].ch);
      end else chk("t5_pending", 0, 1);
      chk("t5_hold_ready", {28'b0, req_ready}, 0);
    end
    out_ready = 1;
    tick();
    chk("t5_release_valid", 32'(out_valid), 0);
    drain(40);
    // clear during HOLD discards in-flight result and restarts rr at ch0
    pulse_clear();
    push(2, 40);
    push(2, 40);
    drain(40);
    out_ready = 0;
    push(2, 40);
    wait_valid(20);
    pulse_clear();
    chk("t6_cleared_valid", 32'(out_valid), 0);
    out_ready = 1;
    clear_logs();
    push(3, 8);
    push(2, 40);
    drain(40);
    chk("t6_count", out_log.size(), 2);
    if (out_log.size() == 2) begin
      chk("t6_first_grant", acc_log[0], 2);
      chk("t6_second_grant", acc_log[1], 3);
      chk("t6_ch2", out_log[0], 10);
      chk("t6_ch3", out_log[1], 2);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
